swerv_nbload_cam: RTL and testbench

Parametrised tracker for outstanding non-blocking loads in the LSU/decode boundary; successor to the fixed-width `load_cam_pkt_t` usage, generalised to `DEPTH` entries with stale-write (WAW) suppression, cancellation and protocol-error reporting. Decode allocates an entry per issued non-blocking load and gets back a tag. Decode queries the CAM for RAW hazards on rs1/rs2. The LSU returns data by tag, and the block emits a registered register-file write-enable per completed load.

---
 rtl/swerv_nbload_cam_if.sv | 43 ++++
 rtl/swerv_nbload_cam.sv | 148 ++++++++++++++
 tb/tb_swerv_nbload_cam.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/swerv_nbload_cam_if.sv
// rtl/swerv_nbload_cam_if.sv - decode/LSU side bundle of the non-blocking load CAM
// Parameters: DEPTH (entries), TAG_W (derived tag width)
// master (decode/LSU): drives alloc_valid/alloc_rd, wb_valid/wb_tag,
//   cancel_valid/cancel_tag, rs1_addr/rs2_addr; observes alloc_ready/alloc_tag,
//   rs1_hit/rs2_hit, nb_wb_valid/nb_wb_rd/nb_wb_tag/nb_wb_wen, count, proto_err
// slave (CAM): the mirror image of master
interface swerv_nbload_cam_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = $clog2(DEPTH)
);
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic             cancel_valid;
  logic [TAG_W-1:0] cancel_tag;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             nb_wb_valid;
  logic [4:0]       nb_wb_rd;
  logic [TAG_W-1:0] nb_wb_tag;
  logic             nb_wb_wen;
  logic [TAG_W:0]   count;
  logic             proto_err;

  modport master (
    output alloc_valid, alloc_rd, wb_valid, wb_tag, cancel_valid, cancel_tag,
           rs1_addr, rs2_addr,
    input  alloc_ready, alloc_tag, rs1_hit, rs2_hit, nb_wb_valid, nb_wb_rd,
           nb_wb_tag, nb_wb_wen, count, proto_err
  );

  modport slave (
    input  alloc_valid, alloc_rd, wb_valid, wb_tag, cancel_valid, cancel_tag,
           rs1_addr, rs2_addr,
    output alloc_ready, alloc_tag, rs1_hit, rs2_hit, nb_wb_valid, nb_wb_rd,
           nb_wb_tag, nb_wb_wen, count, proto_err
  );
endinterface

// File: rtl/swerv_nbload_cam.sv
// rtl/swerv_nbload_cam.sv - outstanding non-blocking load tracker with WAW suppression
// Ports: clk, rst_l (async active-low), bus (swerv_nbload_cam_if.slave):
//   allocate (alloc_valid/alloc_rd -> alloc_ready/alloc_tag), writeback by tag
//   (wb_valid/wb_tag), cancel by tag (cancel_valid/cancel_tag), RAW lookup
//   (rs1/rs2_addr -> rs1/rs2_hit), registered completion (nb_wb_*), count, proto_err.
// Option: RV_NBLOAD_WB_BYPASS_EN - lookup ignores the entry being written back this cycle.
module swerv_nbload_cam #(
  parameter  int DEPTH = 4,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                rst_l,
  swerv_nbload_cam_if.slave  bus
);

  logic [DEPTH-1:0] valid_q, stale_q, valid_d, stale_d, live;
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];

  logic [TAG_W-1:0] free_tag;
  logic             any_free;
  logic             wb_hit, cancel_hit, wb_stale;
  logic [4:0]       wb_rd;
  logic             alloc_fire, full_err, wb_fire, wb_err, cancel_fire;
  logic [TAG_W:0]   cnt_d, count_q;
  logic             nb_valid_q, nb_wen_q, err_q;
  logic [4:0]       nb_rd_q;
  logic [TAG_W-1:0] nb_tag_q;

  // Free list from registered valid bits only; descending scan leaves the lowest index.
  always_comb begin
    any_free = 1'b0;
    free_tag = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_tag = TAG_W'(i);
      end
    end
  end

  // Tag-addressed reads done by compare so non-power-of-two DEPTH never indexes past the array.
  always_comb begin
    wb_hit     = 1'b0;
    wb_rd      = '0;
    wb_stale   = 1'b0;
    cancel_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.wb_tag == TAG_W'(i)) begin
        wb_hit   = valid_q[i];
        wb_rd    = rd_q[i];
        wb_stale = stale_q[i];
      end
      if (bus.cancel_tag == TAG_W'(i)) cancel_hit = valid_q[i];
    end
  end

  assign alloc_fire  = bus.alloc_valid && any_free;
  assign full_err    = bus.alloc_valid && !any_free;
  assign cancel_fire = bus.cancel_valid && cancel_hit;
  // A same-tag cancel swallows the writeback entirely.
  assign wb_fire     = bus.wb_valid && wb_hit &&
                       !(bus.cancel_valid && (bus.cancel_tag == bus.wb_tag));
  assign wb_err      = bus.wb_valid && !wb_hit;

  always_comb begin
    valid_d = valid_q;
    stale_d = stale_q;
    rd_d    = rd_q;
    for (int i = 0; i < DEPTH; i++) begin
      // Older writers of the same rd lose their register-file write.
      if (alloc_fire && valid_q[i] && (rd_q[i] == bus.alloc_rd) && (bus.alloc_rd != 5'd0))
        stale_d[i] = 1'b1;
      if ((wb_fire && (bus.wb_tag == TAG_W'(i))) ||
          (cancel_fire && (bus.cancel_tag == TAG_W'(i)))) begin
        valid_d[i] = 1'b0;
        stale_d[i] = 1'b0;
      end
      // The allocated slot was free at the edge, so it never collides with the frees above.
      if (alloc_fire && (free_tag == TAG_W'(i))) begin
        valid_d[i] = 1'b1;
        stale_d[i] = 1'b0;
        rd_d[i]    = bus.alloc_rd;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_d[i]) cnt_d = cnt_d + (TAG_W + 1)'(1);
    end
  end

  always_comb begin
    live = valid_q & ~stale_q;
`ifdef RV_NBLOAD_WB_BYPASS_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.wb_valid && (bus.wb_tag == TAG_W'(i))) live[i] = 1'b0;
    end
`endif
  end

  always_comb begin
    bus.rs1_hit = 1'b0;
    bus.rs2_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (rd_q[i] == bus.rs1_addr) && (bus.rs1_addr != 5'd0)) bus.rs1_hit = 1'b1;
      if (live[i] && (rd_q[i] == bus.rs2_addr) && (bus.rs2_addr != 5'd0)) bus.rs2_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid_q    <= '0;
      stale_q    <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
      count_q    <= '0;
      nb_valid_q <= 1'b0;
      nb_rd_q    <= '0;
      nb_tag_q   <= '0;
      nb_wen_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      stale_q    <= stale_d;
      rd_q       <= rd_d;
      count_q    <= cnt_d;
      nb_valid_q <= wb_fire;
      nb_wen_q   <= wb_fire && !wb_stale && (wb_rd != 5'd0);
      err_q      <= full_err || wb_err;
      if (wb_fire) begin
        nb_rd_q  <= wb_rd;
        nb_tag_q <= bus.wb_tag;
      end
    end
  end

  assign bus.alloc_ready = any_free;
  assign bus.alloc_tag   = free_tag;
  assign bus.nb_wb_valid = nb_valid_q;
  assign bus.nb_wb_rd    = nb_rd_q;
  assign bus.nb_wb_tag   = nb_tag_q;
  assign bus.nb_wb_wen   = nb_wen_q;
  assign bus.count       = count_q;
  assign bus.proto_err   = err_q;

endmodule

// File: tb/tb_swerv_nbload_cam.sv
// tb/tb_swerv_nbload_cam.sv - vector table plus completion scoreboard for swerv_nbload_cam
module tb_swerv_nbload_cam;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  swerv_nbload_cam_if #(.DEPTH(4)) bus ();
  swerv_nbload_cam #(.DEPTH(4)) dut (.clk(clk), .rst_l(rst_l), .bus(bus));

`ifdef RV_NBLOAD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic av; logic [4:0] ard; logic wv; logic [1:0] wt; logic cv; logic [1:0] ct;
    logic [4:0] r1; logic [4:0] r2;
    logic e_ready; logic [1:0] e_tag; logic e_h1; logic e_h2;
    logic e_cmp; logic [4:0] e_rd; logic e_wen; logic e_err; logic [2:0] e_cnt;
  } vec_t;

  typedef struct { logic [4:0] rd; logic [1:0] tag; logic wen; } cmp_t;

  vec_t vecs[$];
  cmp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic wv, input logic [1:0] wt,
    input logic cv, input logic [1:0] ct, input logic [4:0] r1, input logic [4:0] r2,
    input logic er, input logic [1:0] et, input logic eh1, input logic eh2,
    input logic ec, input logic [4:0] erd, input logic ewen, input logic eerr,
    input logic [2:0] ecnt);
    vec_t v;
    v.av = av; v.ard = ard; v.wv = wv; v.wt = wt; v.cv = cv; v.ct = ct; v.r1 = r1; v.r2 = r2;
    v.e_ready = er; v.e_tag = et; v.e_h1 = eh1; v.e_h2 = eh2;
    v.e_cmp = ec; v.e_rd = erd; v.e_wen = ewen; v.e_err = eerr; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.alloc_valid = 1'b0; bus.alloc_rd = '0; bus.wb_valid = 1'b0; bus.wb_tag = '0;
    bus.cancel_valid = 1'b0; bus.cancel_tag = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;
  endtask

  // Registered outputs checked on the falling edge after the cycle's rising edge.
  task automatic check_regs(input string tag, input logic e_err, input logic [2:0] e_cnt);
    cmp_t c;
    chk({tag, " proto_err"}, bus.proto_err, e_err);
    chk({tag, " count"}, bus.count, e_cnt);
    chk({tag, " nb_wb_valid"}, bus.nb_wb_valid, (sb.size() != 0));
    if (bus.nb_wb_valid && sb.size() != 0) begin
      c = sb.pop_front();
      chk({tag, " nb_wb_rd"}, bus.nb_wb_rd, c.rd);
      chk({tag, " nb_wb_tag"}, bus.nb_wb_tag, c.tag);
      chk({tag, " nb_wb_wen"}, bus.nb_wb_wen, c.wen);
    end
    sb.delete();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    cmp_t c;
    t = $sformatf("v%0d", idx);
    bus.alloc_valid = v.av; bus.alloc_rd = v.ard; bus.wb_valid = v.wv; bus.wb_tag = v.wt;
    bus.cancel_valid = v.cv; bus.cancel_tag = v.ct; bus.rs1_addr = v.r1; bus.rs2_addr = v.r2;
    #1;
    chk({t, " alloc_ready"}, bus.alloc_ready, v.e_ready);
    if (v.e_ready) chk({t, " alloc_tag"}, bus.alloc_tag, v.e_tag);
    chk({t, " rs1_hit"}, bus.rs1_hit, v.e_h1);
    chk({t, " rs2_hit"}, bus.rs2_hit, v.e_h2);
    if (v.e_cmp) begin
      c.rd = v.e_rd; c.tag = v.wt; c.wen = v.e_wen;
      sb.push_back(c);
    end
    @(negedge clk);
    check_regs(t, v.e_err, v.e_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic nb = !BYP;
    //         av ard wv wt cv ct r1 r2  rdy tag h1 h2  cmp rd wen err cnt
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 5,  1, 1, 1, 1,  0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5, 0,  1, 1, nb, 0, 1, 5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 0,  1, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 7,  1, 0, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 7,  1, 1, 0, 1,  0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7,  1, 2, 0, 1,  0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 7,  1, 2, 0, 1,  1, 7, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 7,  1, 0, 0, nb, 1, 7, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7,  1, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0,  0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0,  0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 6, 0, 0, 0, 0, 3, 0,  0, 0, 1, 0,  0, 0, 0, 1, 4));
    vecs.push_back(mk(1, 6, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0,  1, 3, 1, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0,  0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0,  1, 2, 0, 0,  0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1,  1, 2, 0, 1,  1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 9, 1, 1, 0, 0, 9, 0,  1, 0, nb, 0, 1, 9, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0,  1, 1, 1, 0,  0, 0, 0, 0, 1));

    drive_idle();
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset count", bus.count, 0);
    chk("reset nb_wb_valid", bus.nb_wb_valid, 0);
    chk("reset nb_wb_rd", bus.nb_wb_rd, 0);
    chk("reset nb_wb_wen", bus.nb_wb_wen, 0);
    chk("reset proto_err", bus.proto_err, 0);
    chk("reset alloc_ready", bus.alloc_ready, 1);
    chk("reset alloc_tag", bus.alloc_tag, 0);
    rst_l = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Completion in flight when reset hits: entry 0 holds rd 9.
    bus.wb_valid = 1'b1; bus.wb_tag = 2'd0; bus.rs1_addr = 5'd9;
    @(posedge clk);
    #1;
    chk("rst pre nb_wb_valid", bus.nb_wb_valid, 1);
    bus.wb_valid = 1'b0;
    rst_l = 1'b0;
    #1;
    chk("rst nb_wb_valid", bus.nb_wb_valid, 0);
    chk("rst count", bus.count, 0);
    chk("rst rs1_hit", bus.rs1_hit, 0);
    chk("rst alloc_tag", bus.alloc_tag, 0);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    chk("post rst nb_wb_valid", bus.nb_wb_valid, 0);
    chk("post rst count", bus.count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
